// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
//   Front end for the SHA-256 compression core. It collects a byte stream into
//   512-bit blocks and applies SHA-256 padding: a 0x80 marker, a zero fill and
//   the 64-bit big-endian message length in bits. It starts the core once per
//   block and returns the final digest with a one-cycle valid pulse.
//
// Ports
//   clk, rst        clock; synchronous active-high reset (shared with the core)
//   s_data/s_valid  message byte stream; s_last marks the final byte
//   s_ready         a byte is accepted when s_valid & s_ready
//   empty_req       pulse while idle to hash the zero-length message
//   core_block      block for the core, byte 0 in [511:504]
//   core_start      one-cycle start pulse; core_first_run selects the IV
//   core_hash       core result; core_ready marks the core as done/idle
//   digest          final hash, held until the next digest_valid pulse
//   busy            high whenever the padder is not idle
// -----------------------------------------------------------------------------
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    input  logic         empty_req,
    output logic [511:0] core_block,
    output logic         core_start,
    output logic         core_first_run,
    input  logic [255:0] core_hash,
    input  logic         core_ready,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, LOAD, PAD, EXTRA, START, WAIT, FIN} state_t;

    state_t           state;
    state_t           ret_state;   // where a non-final block continues after the core
    logic [5:0]       ptr;
    logic [LEN_W-1:0] bitlen;
    logic             first;       // next block is the first of its message
    logic             final_blk;   // block in flight carries the length field
    logic             need_80;     // message filled a block exactly; marker still owed
    logic             wait_armed;  // skips the first WAIT cycle

    function automatic logic [63:0] len_field(input logic [LEN_W-1:0] len);
        logic [63:0] r;
        r = '0;
        r[LEN_W-1:0] = len;
        return r;
    endfunction

    function automatic logic [511:0] put_byte(input logic [511:0] blk,
                                              input logic [5:0]   p,
                                              input logic [7:0]   d);
        logic [511:0] r;
        r = blk;
        r[8*(63-int'(p)) +: 8] = d;
        return r;
    endfunction

    // Marker at byte p, zeros above it; the length only fits if p <= 55.
    function automatic logic [511:0] pad_block(input logic [511:0] blk,
                                               input logic [5:0]   p,
                                               input logic [63:0]  len);
        logic [511:0] r;
        r = blk;
        for (int i = 0; i < 64; i++) begin
            if (i == int'(p))
                r[8*(63-i) +: 8] = 8'h80;
            else if (i > int'(p))
                r[8*(63-i) +: 8] = 8'h00;
        end
        if (p <= 6'd55)
            r[63:0] = len;
        return r;
    endfunction

    function automatic logic [511:0] extra_block(input logic        with_80,
                                                 input logic [63:0] len);
        logic [511:0] r;
        r = '0;
        if (with_80)
            r[511:504] = 8'h80;
        r[63:0] = len;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ret_state      <= LOAD;
            ptr            <= '0;
            bitlen         <= '0;
            first          <= 1'b1;
            final_blk      <= 1'b0;
            need_80        <= 1'b0;
            wait_armed     <= 1'b0;
            s_ready        <= 1'b0;
            core_block     <= '0;
            core_start     <= 1'b0;
            core_first_run <= 1'b0;
            digest         <= '0;
            digest_valid   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            core_start   <= 1'b0;
            digest_valid <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (s_valid && s_ready) begin
                        core_block <= put_byte(core_block, ptr, s_data);
                        ptr        <= ptr + 6'd1;
                        bitlen     <= bitlen + LEN_W'(8);
                        busy       <= 1'b1;
                        if (ptr == 6'd63) begin
                            // Full block: hash it now; a final byte here leaves
                            // marker and length for an extra block.
                            state          <= START;
                            s_ready        <= 1'b0;
                            core_start     <= 1'b1;
                            core_first_run <= first;
                            final_blk      <= 1'b0;
                            need_80        <= s_last;
                            ret_state      <= s_last ? EXTRA : LOAD;
                        end else if (s_last) begin
                            state   <= PAD;
                            s_ready <= 1'b0;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end else if (state == IDLE && empty_req && !s_valid) begin
                        state   <= PAD;
                        ptr     <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                PAD: begin
                    core_block     <= pad_block(core_block, ptr, len_field(bitlen));
                    state          <= START;
                    core_start     <= 1'b1;
                    core_first_run <= first;
                    if (ptr <= 6'd55) begin
                        final_blk <= 1'b1;
                    end else begin
                        final_blk <= 1'b0;
                        need_80   <= 1'b0;
                        ret_state <= EXTRA;
                    end
                end
                EXTRA: begin
                    core_block     <= extra_block(need_80, len_field(bitlen));
                    state          <= START;
                    core_start     <= 1'b1;
                    core_first_run <= first;
                    final_blk      <= 1'b1;
                end
                START: begin
                    state          <= WAIT;
                    wait_armed     <= 1'b0;
                    core_first_run <= 1'b0;
                end
                WAIT: begin
                    // core_ready may still read high from the previous block on
                    // the first WAIT cycle, so completion is only taken later.
                    if (!wait_armed) begin
                        wait_armed <= 1'b1;
                    end else if (core_ready) begin
                        first <= 1'b0;
                        if (final_blk) begin
                            state <= FIN;
                        end else if (ret_state == LOAD) begin
                            state      <= LOAD;
                            ptr        <= '0;
                            core_block <= '0;
                            s_ready    <= 1'b1;
                        end else begin
                            state <= EXTRA;
                        end
                    end
                end
                FIN: begin
                    digest       <= core_hash;
                    digest_valid <= 1'b1;
                    ptr          <= '0;
                    bitlen       <= '0;
                    need_80      <= 1'b0;
                    final_blk    <= 1'b0;
                    first        <= 1'b1;
                    state        <= IDLE;
                    s_ready      <= 1'b1;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
